// File: rtl/cis_dvp_tx.sv
// cis_dvp_tx: DVP (parallel CIS) transmitter that turns a valid/ready pixel stream into
// sensor-style frames with PCLK/HSYNC/VSYNC. Optional ramp test pattern: CIS_TESTPAT_EN.
module cis_dvp_tx #(
    parameter int unsigned PIX_W     = 10,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_BLANK   = 160,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned VS_LINES  = 2,
    parameter int unsigned VBP_LINES = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             enable,
`ifdef CIS_TESTPAT_EN
    input  logic             test_mode,
`endif
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             cis_pclk,
    output logic [PIX_W-1:0] cis_data,
    output logic             cis_hsync,
    output logic             cis_vsync,
    output logic             busy,
    output logic             frame_done,
    output logic             underrun
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned L_MAX_A = (V_ACTIVE > VS_LINES) ? V_ACTIVE : VS_LINES;
    localparam int unsigned L_MAX   = (L_MAX_A > VBP_LINES) ? L_MAX_A : VBP_LINES;
    localparam int unsigned LW      = (L_MAX > 1) ? $clog2(L_MAX) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW:0]   H_ACT_X  = (HW + 1)'(H_ACTIVE);
    localparam logic [LW-1:0] VS_LAST  = LW'((VS_LINES > 0) ? VS_LINES - 1 : 0);
    localparam logic [LW-1:0] VBP_LAST = LW'((VBP_LINES > 0) ? VBP_LINES - 1 : 0);
    localparam logic [LW-1:0] VA_LAST  = LW'((V_ACTIVE > 0) ? V_ACTIVE - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VSYNC  = 2'd1,
        ST_VBP    = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             phase_q, phase_d;
    logic [HW-1:0]    hcnt_q, hcnt_d;
    logic [LW-1:0]    lcnt_q, lcnt_d;
    logic [PIX_W-1:0] data_q, data_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             underrun_q, underrun_d;
    logic             busy_q, busy_d;

    state_t           nxt_state_s;
    logic [HW-1:0]    nxt_hcnt_s;
    logic [LW-1:0]    nxt_lcnt_s;
    logic             frame_end_s;
    logic             nxt_pix_s;

`ifdef CIS_TESTPAT_EN
    logic             tp_q, tp_d;
    logic [PIX_W-1:0] ramp_s;

    // Ramp value for the upcoming slot: column plus active-line index, wrapping at PIX_W bits.
    always_comb begin
        ramp_s = PIX_W'(nxt_hcnt_s) + PIX_W'(nxt_lcnt_s);
    end
`endif

    // Position of the slot that follows the one currently on the bus.
    always_comb begin
        nxt_state_s = state_q;
        nxt_hcnt_s  = hcnt_q + 1'b1;
        nxt_lcnt_s  = lcnt_q;
        frame_end_s = 1'b0;
        if (hcnt_q == H_LAST) begin
            nxt_hcnt_s = '0;
            nxt_lcnt_s = lcnt_q + 1'b1;
            case (state_q)
                ST_VSYNC: begin
                    if (lcnt_q == VS_LAST) begin
                        nxt_lcnt_s  = '0;
                        nxt_state_s = (VBP_LINES == 0) ? ST_ACTIVE : ST_VBP;
                    end else begin
                        nxt_state_s = ST_VSYNC;
                    end
                end
                ST_VBP: begin
                    if (lcnt_q == VBP_LAST) begin
                        nxt_lcnt_s  = '0;
                        nxt_state_s = ST_ACTIVE;
                    end else begin
                        nxt_state_s = ST_VBP;
                    end
                end
                ST_ACTIVE: begin
                    if (lcnt_q == VA_LAST) begin
                        nxt_lcnt_s  = '0;
                        frame_end_s = 1'b1;
                        nxt_state_s = enable ? ST_VSYNC : ST_IDLE;
                    end else begin
                        nxt_state_s = ST_ACTIVE;
                    end
                end
                default: begin
                    nxt_lcnt_s  = '0;
                    nxt_state_s = ST_IDLE;
                end
            endcase
        end else begin
            nxt_hcnt_s = hcnt_q + 1'b1;
        end
        nxt_pix_s = (nxt_state_s == ST_ACTIVE) && ({1'b0, nxt_hcnt_s} < H_ACT_X);
    end

    // Next-state and slot outputs; slot outputs only move on the edge that drops the phase.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        hcnt_d     = hcnt_q;
        lcnt_d     = lcnt_q;
        data_d     = data_q;
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        busy_d     = busy_q;
        ready_d    = 1'b0;
        done_d     = 1'b0;
        underrun_d = 1'b0;
`ifdef CIS_TESTPAT_EN
        tp_d       = tp_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_VSYNC;
                    phase_d = 1'b0;
                    hcnt_d  = '0;
                    lcnt_d  = '0;
                    data_d  = '0;
                    hsync_d = 1'b0;
                    vsync_d = 1'b1;
                    busy_d  = 1'b1;
`ifdef CIS_TESTPAT_EN
                    tp_d    = test_mode;
`endif
                end else begin
                    state_d = ST_IDLE;
                    phase_d = 1'b0;
                end
            end
            default: begin
                phase_d = ~phase_q;
                if (!phase_q) begin
                    // Mid-slot edge: open s_ready for the clock that ends on the next boundary.
`ifdef CIS_TESTPAT_EN
                    ready_d = nxt_pix_s && !tp_q;
`else
                    ready_d = nxt_pix_s;
`endif
                end else begin
                    state_d = nxt_state_s;
                    hcnt_d  = nxt_hcnt_s;
                    lcnt_d  = nxt_lcnt_s;
                    vsync_d = (nxt_state_s == ST_VSYNC);
                    hsync_d = nxt_pix_s;
                    busy_d  = (nxt_state_s != ST_IDLE);
                    done_d  = frame_end_s;
`ifdef CIS_TESTPAT_EN
                    if (frame_end_s && (nxt_state_s == ST_VSYNC)) begin
                        tp_d = test_mode;
                    end else begin
                        tp_d = tp_q;
                    end
`endif
                    if (nxt_pix_s) begin
`ifdef CIS_TESTPAT_EN
                        if (tp_q) begin
                            data_d = ramp_s;
                        end else if (s_valid) begin
                            data_d = s_data;
                        end else begin
                            data_d     = '0;
                            underrun_d = 1'b1;
                        end
`else
                        if (s_valid) begin
                            data_d = s_data;
                        end else begin
                            data_d     = '0;
                            underrun_d = 1'b1;
                        end
`endif
                    end else begin
                        data_d = '0;
                    end
                end
            end
        endcase
    end

    // State, counters and registered output stage.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            phase_q    <= 1'b0;
            hcnt_q     <= '0;
            lcnt_q     <= '0;
            data_q     <= '0;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            hcnt_q     <= hcnt_d;
            lcnt_q     <= lcnt_d;
            data_q     <= data_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
            busy_q     <= busy_d;
        end
    end

`ifdef CIS_TESTPAT_EN
    // Test-pattern select, latched at each frame start.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tp_q <= 1'b0;
        end else begin
            tp_q <= tp_d;
        end
    end
`endif

    assign s_ready    = ready_q;
    assign cis_pclk   = phase_q;
    assign cis_data   = data_q;
    assign cis_hsync  = hsync_q;
    assign cis_vsync  = vsync_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_cis_dvp_tx.sv
// Directed bench for cis_dvp_tx with a 4+2 slot line, 1+1+3 line frame (60 clocks).
module tb_cis_dvp_tx;
    localparam int PW = 10;

    logic          clk;
    logic          rst;
    logic          enable;
    logic [PW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          cis_pclk;
    logic [PW-1:0] cis_data;
    logic          cis_hsync;
    logic          cis_vsync;
    logic          busy;
    logic          frame_done;
    logic          underrun;
`ifdef CIS_TESTPAT_EN
    logic          test_mode;
`endif

    int n_tests;
    int n_fail;
    int t;
    int consumed;

    cis_dvp_tx #(
        .PIX_W(PW), .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3), .VS_LINES(1), .VBP_LINES(1)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .enable    (enable),
`ifdef CIS_TESTPAT_EN
        .test_mode (test_mode),
`endif
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .cis_pclk  (cis_pclk),
        .cis_data  (cis_data),
        .cis_hsync (cis_hsync),
        .cis_vsync (cis_vsync),
        .busy      (busy),
        .frame_done(frame_done),
        .underrun  (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slot geometry: 6 slots per line, 5 lines per frame, 2 clocks per slot.
    function automatic int line_of(input int tt);
        return ((tt / 2) % 30) / 6;
    endfunction
    function automatic int hpos_of(input int tt);
        return ((tt / 2) % 30) % 6;
    endfunction
    function automatic bit act_of(input int tt);
        return (line_of(tt) >= 2) && (hpos_of(tt) < 4);
    endfunction
    function automatic int pix_of(input int tt);
        return (tt / 60) * 12 + (line_of(tt) - 2) * 4 + hpos_of(tt);
    endfunction
    function automatic logic [16:0] outs();
        return {cis_vsync, cis_hsync, cis_pclk, busy, s_ready, frame_done, underrun, cis_data};
    endfunction

    // One clock: stream word advances #1 after an edge that consumed it; returns at the negedge.
    task automatic step();
        logic take;
        take = s_ready && s_valid;
        @(posedge clk);
        #1;
        if (take) begin
            s_data   = s_data + 10'd1;
            consumed = consumed + 1;
        end
        t = t + 1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        enable  = 1'b0;
        s_valid = 1'b0;
        s_data  = 10'd1;
`ifdef CIS_TESTPAT_EN
        test_mode = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        consumed = 0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        enable  = 1'b1;
        s_valid = 1'b1;
        s_data  = 10'h3ff;
        @(negedge clk);
        n_tests++;
        if (outs() !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b exp %b", outs(), 17'd0);
        end
        enable = 1'b0;
        rst    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (outs() !== 17'd0) begin
                n_fail++;
                $display("FAIL idle_after_reset cyc=%0d got %b exp %b", i, outs(), 17'd0);
            end
        end
    endtask

    task automatic test_frame();
        int vs_hi;
        int hs_line[5];
        logic [PW-1:0] exp_d;
        logic [16:0]   exp_v;
        do_reset();
        s_valid = 1'b1;
        vs_hi   = 0;
        foreach (hs_line[i]) hs_line[i] = 0;
        enable = 1'b1;
        t      = -1;
        step();
        for (int i = 0; i < 60; i++) begin
            exp_d = act_of(t) ? 10'(pix_of(t) + 1) : 10'd0;
            exp_v = {line_of(t) == 0, act_of(t), t[0], 1'b1, t[0] && act_of(t + 1), 1'b0, 1'b0, exp_d};
            n_tests++;
            if (outs() !== exp_v) begin
                n_fail++;
                $display("FAIL frame t=%0d got %b exp %b", t, outs(), exp_v);
            end
            vs_hi += int'(cis_vsync);
            hs_line[line_of(t)] += int'(cis_hsync);
            if (t == 29) enable = 1'b0;
            step();
        end
        n_tests++;
        if (vs_hi !== 12) begin
            n_fail++;
            $display("FAIL vsync_clocks got %0d exp 12", vs_hi);
        end
        for (int l = 2; l < 5; l++) begin
            n_tests++;
            if (hs_line[l] !== 8) begin
                n_fail++;
                $display("FAIL hsync_clocks line=%0d got %0d exp 8", l, hs_line[l]);
            end
        end
        n_tests++;
        if (consumed !== 12) begin
            n_fail++;
            $display("FAIL frame_consumed got %0d exp 12", consumed);
        end
        n_tests++;
        if (outs() !== 17'b0000010_0000000000) begin
            n_fail++;
            $display("FAIL frame_end t=%0d got %b exp %b", t, outs(), 17'b0000010_0000000000);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (outs() !== 17'd0) begin
                n_fail++;
                $display("FAIL idle_after_frame t=%0d got %b exp %b", t, outs(), 17'd0);
            end
        end
    endtask

    task automatic test_underrun();
        int            p;
        int            ur_hits;
        logic [PW-1:0] exp_d;
        logic [16:0]   exp_v;
        do_reset();
        s_valid = 1'b1;
        ur_hits = 0;
        enable  = 1'b1;
        t       = -1;
        step();
        for (int i = 0; i < 60; i++) begin
            p = pix_of(t);
            if (!act_of(t) || p == 1) exp_d = 10'd0;
            else if (p == 0) exp_d = 10'd1;
            else exp_d = 10'(p);
            exp_v = {line_of(t) == 0, act_of(t), t[0], 1'b1, t[0] && act_of(t + 1), 1'b0, t == 26, exp_d};
            n_tests++;
            if (outs() !== exp_v) begin
                n_fail++;
                $display("FAIL underrun_frame t=%0d got %b exp %b", t, outs(), exp_v);
            end
            ur_hits += int'(underrun);
            if (t == 10) enable = 1'b0;
            if (t == 25) s_valid = 1'b0;
            if (t == 26) s_valid = 1'b1;
            step();
        end
        n_tests++;
        if (ur_hits !== 1 || consumed !== 11) begin
            n_fail++;
            $display("FAIL underrun_counts got ur=%0d px=%0d exp ur=1 px=11", ur_hits, consumed);
        end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] exp_d;
        logic [16:0]   exp_v;
        do_reset();
        s_valid = 1'b1;
        enable  = 1'b1;
        t       = -1;
        step();
        for (int i = 0; i < 120; i++) begin
            exp_d = act_of(t) ? 10'(pix_of(t) + 1) : 10'd0;
            exp_v = {line_of(t) == 0, act_of(t), t[0], 1'b1, t[0] && act_of(t + 1), t == 60, 1'b0, exp_d};
            n_tests++;
            if (outs() !== exp_v) begin
                n_fail++;
                $display("FAIL b2b t=%0d got %b exp %b", t, outs(), exp_v);
            end
            if (t == 89) enable = 1'b0;
            step();
        end
        n_tests++;
        if (consumed !== 24 || outs() !== 17'b0000010_0000000000) begin
            n_fail++;
            $display("FAIL b2b_end got px=%0d out=%b exp px=24 out=%b",
                     consumed, outs(), 17'b0000010_0000000000);
        end
    endtask

    task automatic test_reset_mid();
        logic [PW-1:0] base;
        logic [PW-1:0] exp_d;
        logic [16:0]   exp_v;
        do_reset();
        s_valid = 1'b1;
        enable  = 1'b1;
        t       = -1;
        step();
        while (t < 39) step();
        n_tests++;
        if (cis_hsync !== 1'b1 || cis_data === 10'd0) begin
            n_fail++;
            $display("FAIL pre_reset_active got hs=%b d=%0d exp hs=1 d!=0", cis_hsync, cis_data);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (outs() !== 17'd0) begin
            n_fail++;
            $display("FAIL async_reset got %b exp %b", outs(), 17'd0);
        end
        repeat (2) @(negedge clk);
        enable = 1'b0;
        rst    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (outs() !== 17'd0) begin
                n_fail++;
                $display("FAIL wait_idle cyc=%0d got %b exp %b", i, outs(), 17'd0);
            end
        end
        base     = s_data;
        consumed = 0;
        enable   = 1'b1;
        t        = -1;
        step();
        for (int i = 0; i < 60; i++) begin
            exp_d = act_of(t) ? base + 10'(pix_of(t)) : 10'd0;
            exp_v = {line_of(t) == 0, act_of(t), t[0], 1'b1, t[0] && act_of(t + 1), 1'b0, 1'b0, exp_d};
            n_tests++;
            if (outs() !== exp_v) begin
                n_fail++;
                $display("FAIL restart t=%0d got %b exp %b", t, outs(), exp_v);
            end
            if (t == 29) enable = 1'b0;
            step();
        end
        n_tests++;
        if (outs() !== 17'b0000010_0000000000) begin
            n_fail++;
            $display("FAIL restart_end got %b exp %b", outs(), 17'b0000010_0000000000);
        end
    endtask

`ifdef CIS_TESTPAT_EN
    task automatic test_testpat();
        logic [PW-1:0] exp_d;
        logic [16:0]   exp_v;
        do_reset();
        test_mode = 1'b1;
        s_valid   = 1'b1;
        enable    = 1'b1;
        t         = -1;
        step();
        test_mode = 1'b0;
        for (int i = 0; i < 60; i++) begin
            exp_d = act_of(t) ? 10'(hpos_of(t) + line_of(t) - 2) : 10'd0;
            exp_v = {line_of(t) == 0, act_of(t), t[0], 1'b1, 1'b0, 1'b0, 1'b0, exp_d};
            n_tests++;
            if (outs() !== exp_v) begin
                n_fail++;
                $display("FAIL testpat t=%0d got %b exp %b", t, outs(), exp_v);
            end
            if (t == 29) enable = 1'b0;
            step();
        end
        n_tests++;
        if (consumed !== 0) begin
            n_fail++;
            $display("FAIL testpat_consumed got %0d exp 0", consumed);
        end
    endtask
`endif

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        t        = 0;
        consumed = 0;
        rst      = 1'b1;
        enable   = 1'b0;
        s_valid  = 1'b0;
        s_data   = 10'd1;
`ifdef CIS_TESTPAT_EN
        test_mode = 1'b0;
`endif
        test_reset();
        test_frame();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
`ifdef CIS_TESTPAT_EN
        test_testpat();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
